// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx
// Purpose  : FIFO-buffered 8N1 serial transmitter. Characters written with
//            start/ready are queued in a circular FIFO and sent LSB first.
//            Frames are sent back to back with no idle gap.
// Options  : define SERIAL_TX_PARITY_EN to add an even-parity bit after the
//            data bits, which gives an 8E1 frame of 11 bits.
// Revision : 1.0 - initial release
// ============================================================================
module serial_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_AW      = 4
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic [7:0]       data,
  input  logic             start,
  output logic             ready,
  output logic             serial,
  output logic             busy,
  output logic [FIFO_AW:0] level,
  output logic             overflow
);

  localparam int DEPTH = 2 ** FIFO_AW;
  // 13 bits covers the full legal CLKS_PER_BIT range (up to 8191).
  localparam int CNT_W = 13;
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [7:0]           shift_q, shift_d;
  logic                 serial_q, serial_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     level_q, level_d;
  logic                 overflow_q, overflow_d;
`ifdef SERIAL_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif
  logic [7:0]           mem_q [DEPTH];

  logic                 accept;
  logic                 pop;
  logic                 bit_done;
  logic [7:0]           head;

  // ready/level come only from registered occupancy, never from start.
  assign ready    = (level_q != LEVEL_FULL);
  assign accept   = start && ready;
  assign bit_done = (cnt_q == CNT_LAST);
  assign head     = mem_q[rd_ptr_q];

  assign serial   = serial_q;
  assign busy     = (state_q != S_IDLE) || (level_q != '0);
  assign level    = level_q;
  assign overflow = overflow_q;

  // FIFO storage is not reset; the pointers and level alone define validity.
  always_ff @(posedge sysclk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  // FIFO bookkeeping: pointers wrap naturally at depth, level nets push/pop.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + FIFO_AW'(accept);
    rd_ptr_d   = rd_ptr_q + FIFO_AW'(pop);
    level_d    = level_q + (FIFO_AW + 1)'(accept) - (FIFO_AW + 1)'(pop);
    overflow_d = overflow_q || (start && !ready);
  end

  // Frame sequencer: next state, bit timing, shift register and line value.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    pop      = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (level_q != '0) begin
          pop      = 1'b1;
          shift_d  = head;
          serial_d = 1'b0;
          state_d  = S_START;
`ifdef SERIAL_TX_PARITY_EN
          parity_d = ^head;
`endif
        end
      end
      S_START: begin
        if (bit_done) begin
          cnt_d    = '0;
          idx_d    = '0;
          serial_d = shift_q[0];
          shift_d  = {1'b0, shift_q[7:1]};
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
            serial_d = parity_q;
            state_d  = S_PARITY;
`else
            serial_d = 1'b1;
            state_d  = S_STOP;
`endif
          end else begin
            idx_d    = idx_q + 3'd1;
            serial_d = shift_q[0];
            shift_d  = {1'b0, shift_q[7:1]};
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          cnt_d    = '0;
          serial_d = 1'b1;
          state_d  = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          cnt_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (level_q != '0) begin
            pop      = 1'b1;
            shift_d  = head;
            serial_d = 1'b0;
            state_d  = S_START;
`ifdef SERIAL_TX_PARITY_EN
            parity_d = ^head;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        cnt_d    = '0;
        serial_d = 1'b1;
        state_d  = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any frame and parks the line high.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      serial_q   <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      serial_q   <= serial_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule
`default_nettype wire
